// File: rtl/sipo_pkg.sv
// ============================================================================
// sipo_pkg : shared types and helpers for the sipo_rx serial receiver
// Rev 1.0
// ============================================================================
`default_nettype none

package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

    // Bit counter width; a 1-bit floor keeps degenerate widths legal.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_shreg.sv
// ============================================================================
// sipo_shreg : frame shift register and bit counter for sipo_rx
// Rev 1.0
// ============================================================================
`default_nettype none

module sipo_shreg
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             si,
    output logic [WIDTH-1:0] word,
    output logic             last
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shifted = {si, r_sr[WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_shifted = {r_sr[WIDTH-2:0], si};
        end
    endgenerate

    // word already includes the current si, so the final bit is captured on the completing edge.
    assign word = w_shifted;
    assign last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (en) begin
            r_sr  <= w_shifted;
            r_cnt <= last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sipo_rx.sv
// ============================================================================
// sipo_rx : serial-in/parallel-out receiver with buffered valid/ready output
// Rev 1.0
// ============================================================================
`default_nettype none

module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             si,
    input  logic             si_en,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             busy,
    output logic             overrun
);

    sipo_state_t      r_state;
    logic [WIDTH-1:0] w_word;
    logic             w_last;
    logic             w_shift_en;
    logic             w_complete;

    // start wins over si_en, so a restart cycle never shifts its si bit in.
    assign w_shift_en = (r_state == SHIFT) && si_en && !start;
    assign w_complete = w_shift_en && w_last;

    sipo_shreg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .en    (w_shift_en),
        .si    (si),
        .word  (w_word),
        .last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            po       <= '0;
            po_valid <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (po_valid && po_ready) begin
                po_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SHIFT;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_complete) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        // A word consumed on this same edge frees the buffer for the new one.
                        if (!po_valid || po_ready) begin
                            po       <= w_word;
                            po_valid <= 1'b1;
                        end else begin
                            overrun  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
